// File: rtl/led_mode_select.sv
// LED mode selector: debounced mode/brightness keys, mode mux and PWM dimming.
module led_mode_select #(
  parameter int unsigned DEB_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_bri_n,
  input  logic [7:0] led_m0,
  input  logic [7:0] led_m1,
  input  logic [7:0] led_m2,
  input  logic [7:0] led_m3,
  output logic [7:0] led_out,
  output logic [1:0] mode,
  output logic       mode_chg
);

  localparam int unsigned NKEY  = 2;
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned DUTY_W = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  // Bit 0 is the mode key, bit 1 the brightness key.
  logic [NKEY-1:0]            key_raw;
  logic [NKEY-1:0]            sync1;
  logic [NKEY-1:0]            sync2;
  logic [NKEY-1:0]            stable;
  logic [NKEY-1:0]            stable_d;
  logic [NKEY-1:0][CNT_W-1:0] deb_cnt;
  logic [NKEY-1:0]            press_c;
  logic [1:0]                 level;
  logic [7:0]                 pwm_cnt;
  logic [DUTY_W-1:0]          duty_c;
  logic                       pwm_on_c;
  logic [7:0]                 led_sel_c;

  assign key_raw = {key_bri_n, key_mode_n};

  // Two-flop synchronizers; idle (released) level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Debouncers: accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable  <= '1;
      deb_cnt <= '0;
    end else begin
      for (int i = 0; i < int'(NKEY); i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_MAX) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Previous debounced level, used to find the 1->0 (press) transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= '1;
    end else begin
      stable_d <= stable;
    end
  end

  assign press_c = stable_d & ~stable;

  // Mode and brightness level stepping; mode_chg pulses with each mode step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= 2'd0;
      mode_chg <= 1'b0;
      level    <= 2'd0;
    end else begin
      mode_chg <= press_c[0];
      if (press_c[0]) begin
        mode <= mode + 2'd1;
      end
      if (press_c[1]) begin
        level <= level + 2'd1;
      end
    end
  end

  // Free-running PWM counter, never disturbed by level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Duty per level (out of 256) and pattern select for the current mode.
  always_comb begin
    duty_c    = DUTY_W'(256);
    led_sel_c = led_m0;
    case (level)
      2'd0:    duty_c = DUTY_W'(256);
      2'd1:    duty_c = DUTY_W'(128);
      2'd2:    duty_c = DUTY_W'(64);
      default: duty_c = DUTY_W'(16);
    endcase
    case (mode)
      2'd0:    led_sel_c = led_m0;
      2'd1:    led_sel_c = led_m1;
      2'd2:    led_sel_c = led_m2;
      default: led_sel_c = led_m3;
    endcase
  end

  assign pwm_on_c = ({1'b0, pwm_cnt} < duty_c);

  // Registered LED drive, gated by the PWM phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= 8'h00;
    end else begin
      led_out <= pwm_on_c ? led_sel_c : 8'h00;
    end
  end

endmodule

// File: doc/led_mode_select.md
LED_MODE_SELECT -- requirements
Module: led_mode_select

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 240000, debounce hold time in clk cycles (20 ms at 12 MHz); benches override it with a small value.
REQ-002 SHALL have port clk  input  1  system clock, 12 MHz; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port key_mode_n  input  1  mode push-button, asynchronous, active-low.
REQ-005 SHALL have port key_bri_n  input  1  brightness push-button, asynchronous, active-low.
REQ-006 SHALL have ports led_m0, led_m1, led_m2, led_m3  input  8 each  LED patterns from the mode 0..3 drivers.
REQ-007 SHALL have port led_out  output  8  final LED drive; 1 means LED on.
REQ-008 SHALL have port mode  output  2  current mode index.
REQ-009 SHALL have port mode_chg  output  1  one-cycle pulse on every mode change; downstream drivers use it to restart their sequences.

Function
REQ-010 Each key SHALL pass through two synchronizer flops (s1, s2), both reset to 1.
REQ-011 Each key SHALL have its own debouncer: a stable flag reset to 1 and a counter reset to 0.
- s2 equal to stable: counter cleared.
- s2 differs from stable: counter increments.
- On an edge where s2 differs from stable and counter equals DEB_CYCLES-1: stable takes s2 and counter clears.
REQ-012 A press event SHALL be a stable 1->0 transition, detected on the next edge; releases (0->1) SHALL be debounced the same way and produce no event.
REQ-013 Any bounce that returns s2 to the stable value before DEB_CYCLES consecutive differing samples SHALL produce no event.
REQ-014 Latency: if s2 is first low after edge 2, stable SHALL fall at edge DEB_CYCLES+2, and mode/mode_chg SHALL update at edge DEB_CYCLES+3.
REQ-015 A mode press event SHALL set mode to mode+1 modulo 4 (3 wraps to 0) and assert mode_chg for exactly that one cycle.
REQ-016 A brightness press event SHALL set the 2-bit level register to level+1 modulo 4.
REQ-017 Duty per level, out of 256: level 0 = 256 (always on), 1 = 128, 2 = 64, 3 = 16.
REQ-018 An 8-bit PWM counter SHALL run freely from 0 to 255 and wrap to 0; pwm_on = (counter < duty), with duty compared at 9-bit width.
REQ-019 led_out SHALL be registered: led_out <= pwm_on ? led_m[mode] : 8'h00, giving one cycle of latency from led_mX and from mode.
REQ-020 Simultaneous events on both keys in the same cycle SHALL both take effect in that cycle.
REQ-021 A level change SHALL NOT reset the PWM counter and SHALL NOT pulse mode_chg.
REQ-022 Held keys SHALL produce exactly one event per press; there is no auto-repeat.

Reset
REQ-023 While rst_n=0, without waiting for a clock edge, the following SHALL take their reset values:
- 0: led_out, mode, mode_chg, level, PWM counter, debounce counters.
- 1: synchronizer flops, stable flags.
REQ-024 Reset asserted mid-debounce or mid-pulse SHALL discard the pending event; after release no event SHALL fire unless a key is held low for a full DEB_CYCLES again.
REQ-025 A key held low across reset release SHALL produce one press event DEB_CYCLES+3 edges after release.

Verification (DEB_CYCLES=16)
REQ-026 Clean press: key_mode_n low for 40 cycles -> mode 0->1 and mode_chg high for exactly one cycle, at edge 19 counted from the first sampling edge of the low level.
REQ-027 Bounce: key_mode_n low 10 cycles, high 2, low 10, then high -> mode stays 0, mode_chg never asserts.
REQ-028 Wrap and mux: led_mK = 8'h11*(K+1), four clean presses -> mode 1,2,3,0, and led_out = 8'h22, 8'h33, 8'h44, 8'h11 one cycle after each change at level 0.
REQ-029 PWM: led_m0 = 8'hFF, one brightness press (level 1) -> led_out = 8'hFF for exactly 128 of every 256 cycles; after two more presses (level 3) -> exactly 16 of every 256.
REQ-030 Simultaneous presses: both keys low on the same cycle for 40 cycles -> mode and level increment on the same edge; single mode_chg pulse.
REQ-031 Async reset: rst_n driven low between clock edges while mode = 2 -> led_out = 0, mode = 0, mode_chg = 0 before the next edge.
